// File: rtl/tthbif_pkg.sv
// Shared constants, FSM state encoding and lane config layout for the tthbif UART register file.
package tthbif_pkg;

    localparam logic [3:0] AddrId      = 4'h0;
    localparam logic [3:0] AddrStatus  = 4'h1;
    localparam logic [3:0] AddrLane0   = 4'h2;
    localparam logic [3:0] AddrScratch = 4'hF;

    localparam logic [7:0] IdValue  = 8'h48;
    localparam logic [7:0] AckValue = 8'hA5;

    localparam int unsigned CmdWrBit   = 7;
    localparam int unsigned CmdAddrMsb = 3;
    localparam int unsigned CmdAddrLsb = 0;

    typedef enum logic [1:0] {
        StIdle,
        StWdata,
        StResp
    } state_e;

    typedef struct packed {
        logic [1:0] flop_tap_sel;
        logic [1:0] comb_tap_sel;
    } lane_cfg_t;

    localparam lane_cfg_t LaneCfgReset = '{flop_tap_sel: 2'b11, comb_tap_sel: 2'b11};

endpackage

// File: rtl/tthbif_rf.sv
// UART-driven register file for per-lane tap selects.
// Define TTHBIF_RF_WACK_EN to have every completed write answered with an ack byte.
module tthbif_rf #(
    parameter int unsigned NUM_LANES = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   en_i,
    input  logic                   rx_data_valid_i,
    input  logic [7:0]             rx_data_i,
    output logic                   tx_data_valid_o,
    output logic [7:0]             tx_data_o,
    input  logic                   tx_data_ready_i,
    output logic [2*NUM_LANES-1:0] comb_tap_sel_o,
    output logic [2*NUM_LANES-1:0] flop_tap_sel_o
);
    import tthbif_pkg::*;

    state_e     state_q, state_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       drop_q, drop_d;
    logic [7:0] scratch_q, scratch_d;
    logic [3:0] waddr_q, waddr_d;
    lane_cfg_t  lane_cfg_q [NUM_LANES];
    lane_cfg_t  lane_cfg_d [NUM_LANES];

    logic       cmd_wr;
    logic [3:0] cmd_addr;
    logic [7:0] rd_data;

    assign cmd_wr   = rx_data_i[CmdWrBit];
    assign cmd_addr = rx_data_i[CmdAddrMsb:CmdAddrLsb];

    always_comb begin
        rd_data = 8'h00;
        if (cmd_addr == AddrId) begin
            rd_data = IdValue;
        end else if (cmd_addr == AddrStatus) begin
            rd_data = {7'b0, drop_q};
        end else if (cmd_addr == AddrScratch) begin
            rd_data = scratch_q;
        end
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (cmd_addr == 4'(32'(AddrLane0) + i)) begin
                rd_data = {4'h0, lane_cfg_q[i]};
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        drop_d    = drop_q;
        scratch_d = scratch_q;
        waddr_d   = waddr_q;
        lane_cfg_d = lane_cfg_q;

        if (!en_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (rx_data_valid_i) begin
                        if (cmd_wr) begin
                            waddr_d = cmd_addr;
                            state_d = StWdata;
                        end else begin
                            tx_data_d = rd_data;
                            state_d   = StResp;
                            // Status returns the pre-clear DROP value.
                            if (cmd_addr == AddrStatus) begin
                                drop_d = 1'b0;
                            end
                        end
                    end
                end
                StWdata: begin
                    if (rx_data_valid_i) begin
                        if (waddr_q == AddrScratch) begin
                            scratch_d = rx_data_i;
                        end
                        for (int unsigned i = 0; i < NUM_LANES; i++) begin
                            if (waddr_q == 4'(32'(AddrLane0) + i)) begin
                                lane_cfg_d[i] = rx_data_i[3:0];
                            end
                        end
`ifdef TTHBIF_RF_WACK_EN
                        tx_data_d = AckValue;
                        state_d   = StResp;
`else
                        state_d   = StIdle;
`endif
                    end
                end
                StResp: begin
                    if (rx_data_valid_i) begin
                        drop_d = 1'b1;
                    end
                    if (tx_data_ready_i) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            tx_data_q  <= 8'h00;
            drop_q     <= 1'b0;
            scratch_q  <= 8'h00;
            waddr_q    <= 4'h0;
            lane_cfg_q <= '{default: LaneCfgReset};
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            drop_q     <= drop_d;
            scratch_q  <= scratch_d;
            waddr_q    <= waddr_d;
            lane_cfg_q <= lane_cfg_d;
        end
    end

    assign tx_data_valid_o = (state_q == StResp);
    assign tx_data_o       = tx_data_q;

    always_comb begin
        comb_tap_sel_o = '0;
        flop_tap_sel_o = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            comb_tap_sel_o[2*i +: 2] = lane_cfg_q[i].comb_tap_sel;
            flop_tap_sel_o[2*i +: 2] = lane_cfg_q[i].flop_tap_sel;
        end
    end

endmodule

// File: tb/tb_tthbif_rf.sv
// Self-checking bench for tthbif_rf (single lane) against a transaction-level register model.
module tb_tthbif_rf;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       en_i = 1'b1;
    logic       rx_data_valid_i = 1'b0;
    logic [7:0] rx_data_i = 8'h00;
    logic       tx_data_valid_o;
    logic [7:0] tx_data_o;
    logic       tx_data_ready_i = 1'b0;
    logic [1:0] comb_tap_sel_o;
    logic [1:0] flop_tap_sel_o;

    int checks = 0;
    int errors = 0;

    tthbif_rf #(.NUM_LANES(1)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .en_i           (en_i),
        .rx_data_valid_i(rx_data_valid_i),
        .rx_data_i      (rx_data_i),
        .tx_data_valid_o(tx_data_valid_o),
        .tx_data_o      (tx_data_o),
        .tx_data_ready_i(tx_data_ready_i),
        .comb_tap_sel_o (comb_tap_sel_o),
        .flop_tap_sel_o (flop_tap_sel_o)
    );

    always #5 clk_i = ~clk_i;

    // Register model: a response either pending or not, a write either awaiting data or not.
    logic       m_pend, m_wait, m_drop;
    logic [3:0] m_addr;
    logic [7:0] m_resp, m_scratch, m_lane0;

    function automatic logic [7:0] model_read(input logic [3:0] a);
        case (a)
            4'h0:    return 8'h48;
            4'h1:    return {7'b0, m_drop};
            4'h2:    return {4'h0, m_lane0[3:0]};
            4'hF:    return m_scratch;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_pend <= 1'b0; m_wait <= 1'b0; m_drop <= 1'b0; m_addr <= 4'h0;
            m_resp <= 8'h00; m_scratch <= 8'h00; m_lane0 <= 8'h0F;
        end else if (!en_i) begin
            m_pend <= 1'b0; m_wait <= 1'b0;
        end else if (m_pend) begin
            if (rx_data_valid_i) m_drop <= 1'b1;
            if (tx_data_ready_i) m_pend <= 1'b0;
        end else if (m_wait) begin
            if (rx_data_valid_i) begin
                if (m_addr == 4'h2) m_lane0 <= {4'h0, rx_data_i[3:0]};
                if (m_addr == 4'hF) m_scratch <= rx_data_i;
                m_wait <= 1'b0;
`ifdef TTHBIF_RF_WACK_EN
                m_pend <= 1'b1;
                m_resp <= 8'hA5;
`endif
            end
        end else if (rx_data_valid_i) begin
            if (rx_data_i[7]) begin
                m_wait <= 1'b1;
                m_addr <= rx_data_i[3:0];
            end else begin
                m_pend <= 1'b1;
                m_resp <= model_read(rx_data_i[3:0]);
                if (rx_data_i[3:0] == 4'h1) m_drop <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) begin
        chk("model_valid", {7'b0, tx_data_valid_o}, {7'b0, m_pend});
        if (m_pend) chk("model_data", tx_data_o, m_resp);
        chk("model_comb", {6'b0, comb_tap_sel_o}, {6'b0, m_lane0[1:0]});
        chk("model_flop", {6'b0, flop_tap_sel_o}, {6'b0, m_lane0[3:2]});
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_i);
        rx_data_valid_i = 1'b1;
        rx_data_i       = b;
        @(negedge clk_i);
        rx_data_valid_i = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!tx_data_valid_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        if (!tx_data_valid_o) begin
            checks++;
            errors++;
            $display("FAIL %s: no tx byte within 20 cycles", name);
        end
    endtask

    task automatic handshake();
        tx_data_ready_i = 1'b1;
        @(negedge clk_i);
        tx_data_ready_i = 1'b0;
    endtask

    task automatic do_read(input string name, input logic [7:0] cmd, input logic [7:0] exp);
        send_byte(cmd);
        wait_valid(name);
        chk(name, tx_data_o, exp);
        handshake();
        chk({name, "_done"}, {7'b0, tx_data_valid_o}, 8'h00);
    endtask

    task automatic do_write(input string name, input logic [3:0] a, input logic [7:0] d);
        send_byte({4'h8, a});
        send_byte(d);
`ifdef TTHBIF_RF_WACK_EN
        wait_valid(name);
        chk({name, "_ack"}, tx_data_o, 8'hA5);
        handshake();
`else
        repeat (4) begin
            @(negedge clk_i);
            chk({name, "_noack"}, {7'b0, tx_data_valid_o}, 8'h00);
        end
`endif
    endtask

    initial begin
        repeat (2) @(negedge clk_i);
        chk("rst_valid", {7'b0, tx_data_valid_o}, 8'h00);
        chk("rst_data", tx_data_o, 8'h00);
        chk("rst_comb", {6'b0, comb_tap_sel_o}, 8'h03);
        chk("rst_flop", {6'b0, flop_tap_sel_o}, 8'h03);
        rst_ni = 1'b1;
        @(negedge clk_i);

        do_read("rd_lane_rst", 8'h02, 8'h0F);

        do_write("wr_lane", 4'h2, 8'h06);
        do_read("rd_lane", 8'h02, 8'h06);
        chk("lane_comb", {6'b0, comb_tap_sel_o}, 8'h02);
        chk("lane_flop", {6'b0, flop_tap_sel_o}, 8'h01);

        // Backpressure: hold the ID response, drop a byte in the middle.
        send_byte(8'h00);
        wait_valid("bp_wait");
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold_valid", {7'b0, tx_data_valid_o}, 8'h01);
            chk("bp_hold_data", tx_data_o, 8'h48);
            rx_data_valid_i = (i == 3);
            rx_data_i       = 8'h01;
            @(negedge clk_i);
        end
        rx_data_valid_i = 1'b0;
        handshake();
        do_read("status_drop", 8'h01, 8'h01);
        do_read("status_clr", 8'h01, 8'h00);

        do_write("wr_id", 4'h0, 8'h55);
        do_read("rd_id", 8'h00, 8'h48);
        do_read("rd_unmapped", 8'h0E, 8'h00);

        en_i = 1'b0;
        send_byte(8'h00);
        repeat (3) begin
            @(negedge clk_i);
            chk("dis_valid", {7'b0, tx_data_valid_o}, 8'h00);
        end
        en_i = 1'b1;
        do_read("dis_retain", 8'h02, 8'h06);

        do_write("wr_scratch", 4'hF, 8'h12);
        do_read("rd_scratch", 8'h0F, 8'h12);

        // Reset lands between a write command and its data byte.
        send_byte(8'h8F);
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("midrst_valid", {7'b0, tx_data_valid_o}, 8'h00);
        chk("midrst_comb", {6'b0, comb_tap_sel_o}, 8'h03);
        rst_ni = 1'b1;
        do_read("midrst_33", 8'h33, 8'h00);
        do_read("midrst_scr", 8'h0F, 8'h00);

        repeat (3) @(negedge clk_i);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
